// File: rtl/rdid_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : rdid_controller_if
//  Purpose  : Bundles the request/status handshake, the captured ID bytes and
//             the SPI flash pins used by rdid_controller.
//  Modports : master - the RDID controller (drives status, IDs, CS/SCK/MOSI)
//             slave  - its environment (drives start and MISO)
//  Signals  : start, busy, done, valid, manufacture_id[7:0], memory_type[7:0],
//             memory_capacity[7:0], CS (active-low), SCK, MOSI, MISO
//  Revision : 1.0 - initial release
// ============================================================================
interface rdid_controller_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       valid;
   logic [7:0] manufacture_id;
   logic [7:0] memory_type;
   logic [7:0] memory_capacity;
   logic       CS;
   logic       SCK;
   logic       MOSI;
   logic       MISO;

   modport master (
      input  start, MISO,
      output busy, done, valid, manufacture_id, memory_type, memory_capacity,
             CS, SCK, MOSI
   );

   modport slave (
      output start, MISO,
      input  busy, done, valid, manufacture_id, memory_type, memory_capacity,
             CS, SCK, MOSI
   );
endinterface
`default_nettype wire

// File: rtl/rdid_controller.sv
`default_nettype none
// ============================================================================
//  Module   : rdid_controller
//  Purpose  : Runs one SPI-flash Read-Identification transaction (opcode 0x9F,
//             SPI mode 0) per accepted start, returning the three ID bytes
//             as stable registered outputs.
//  Ports    : clk     - system clock, rising edge
//             reset   - asynchronous, active-high
//             bus     - rdid_controller_if.master (handshake, IDs, SPI pins)
//  Params   : CLK_DIV - SCK half-period in clk cycles (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module rdid_controller #(
   parameter int CLK_DIV = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   rdid_controller_if.master bus
);

   localparam int                unsigned c_ph_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_ph_w-1:0] c_ph_last         = c_ph_w'(CLK_DIV - 1);
   localparam logic [7:0]        c_opcode          = 8'h9F;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CS_SETUP = 3'd1,
      S_SHIFT    = 3'd2,
      S_CS_HOLD  = 3'd3,
      S_GAP      = 3'd4
   } state_t;

   state_t              r_state;
   logic [c_ph_w-1:0]   r_phase;
   logic                r_half;     // 0: SCK low half of a bit, 1: high half
   logic [4:0]          r_bit;
   logic [23:0]         r_shift;
   logic                r_cs;
   logic                r_sck;
   logic                r_mosi;
   logic                r_busy;
   logic                r_done;
   logic                r_valid;
   logic [7:0]          r_man;
   logic [7:0]          r_type;
   logic [7:0]          r_cap;

   logic                w_ph_last;
   assign w_ph_last = (r_phase == c_ph_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_half  <= 1'b0;
         r_bit   <= 5'd0;
         r_shift <= 24'd0;
         r_cs    <= 1'b1;
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
         r_man   <= 8'd0;
         r_type  <= 8'd0;
         r_cap   <= 8'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cs    <= 1'b1;
               r_sck   <= 1'b0;
               r_mosi  <= 1'b0;
               r_busy  <= 1'b0;
               r_phase <= '0;
               if (bus.start) begin
                  r_state <= S_CS_SETUP;
                  r_cs    <= 1'b0;
                  r_mosi  <= c_opcode[7];   // first opcode bit set up before SCK
                  r_busy  <= 1'b1;
               end
            end

            S_CS_SETUP: begin
               if (w_ph_last) begin
                  r_phase <= '0;
                  r_bit   <= 5'd0;
                  r_half  <= 1'b0;
                  r_state <= S_SHIFT;
               end else begin
                  r_phase <= r_phase + c_ph_w'(1);
               end
            end

            S_SHIFT: begin
               if (w_ph_last) begin
                  r_phase <= '0;
                  if (!r_half) begin
                     // SCK rising edge: flash output is sampled for reply bits
                     r_half <= 1'b1;
                     r_sck  <= 1'b1;
                     if (r_bit >= 5'd8) begin
                        r_shift <= {r_shift[22:0], bus.MISO};
                     end
                  end else begin
                     // SCK falling edge: MOSI moves to the next bit here only
                     r_half <= 1'b0;
                     r_sck  <= 1'b0;
                     if (r_bit == 5'd31) begin
                        r_bit   <= 5'd0;
                        r_mosi  <= 1'b0;
                        r_state <= S_CS_HOLD;
                     end else begin
                        r_bit  <= r_bit + 5'd1;
                        r_mosi <= (r_bit < 5'd7) ? c_opcode[3'd6 - r_bit[2:0]] : 1'b0;
                     end
                  end
               end else begin
                  r_phase <= r_phase + c_ph_w'(1);
               end
            end

            S_CS_HOLD: begin
               if (w_ph_last) begin
                  r_phase <= '0;
                  r_cs    <= 1'b1;
                  r_man   <= r_shift[23:16];
                  r_type  <= r_shift[15:8];
                  r_cap   <= r_shift[7:0];
                  r_valid <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_GAP;
               end else begin
                  r_phase <= r_phase + c_ph_w'(1);
               end
            end

            S_GAP: begin
               // Guarantees a minimum CS-deselect time before the next request
               if (w_ph_last) begin
                  r_phase <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_phase <= r_phase + c_ph_w'(1);
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.CS              = r_cs;
   assign bus.SCK             = r_sck;
   assign bus.MOSI            = r_mosi;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.valid           = r_valid;
   assign bus.manufacture_id  = r_man;
   assign bus.memory_type     = r_type;
   assign bus.memory_capacity = r_cap;

endmodule
`default_nettype wire

// File: tb/tb_rdid_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rdid_controller
//  Purpose  : Self-checking bench for rdid_controller, running one instance
//             with CLK_DIV=4 and one with CLK_DIV=1 against a behavioural
//             flash model that serves queued 24-bit ID responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rdid_controller;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   rdid_controller_if if4 ();
   rdid_controller_if if1 ();

   rdid_controller #(.CLK_DIV(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.master));
   rdid_controller #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.master));

   // index 0 -> CLK_DIV=4 instance, index 1 -> CLK_DIV=1 instance
   logic [1:0]  w_cs, w_sck, w_mosi, w_busy, w_done, w_valid;
   logic [23:0] w_ids [2];
   logic [1:0]  r_miso = 2'b11;

   assign w_cs    = {if1.CS,    if4.CS};
   assign w_sck   = {if1.SCK,   if4.SCK};
   assign w_mosi  = {if1.MOSI,  if4.MOSI};
   assign w_busy  = {if1.busy,  if4.busy};
   assign w_done  = {if1.done,  if4.done};
   assign w_valid = {if1.valid, if4.valid};
   assign w_ids[0] = {if4.manufacture_id, if4.memory_type, if4.memory_capacity};
   assign w_ids[1] = {if1.manufacture_id, if1.memory_type, if1.memory_capacity};
   assign if4.MISO = r_miso[0];
   assign if1.MISO = r_miso[1];

   int n_vec = 0;
   int n_err = 0;

   // ---------------- flash model + bus monitor ----------------
   logic [23:0] resp_tab [2][8];
   int rises_tot [2] = '{0, 0};
   int cs_tot    [2] = '{0, 0};
   int busy_tot  [2] = '{0, 0};
   int hi_tot    [2] = '{0, 0};
   int done_tot  [2] = '{0, 0};
   int glitch    [2] = '{0, 0};
   int txn       [2] = '{0, 0};
   int k         [2] = '{0, 0};
   int hi_run    [2] = '{0, 0};
   int gap_last  [2] = '{0, 0};
   logic [7:0]  op       [2];
   logic [23:0] resp_cur [2];
   logic [23:0] ids_q    [2];
   logic [1:0]  cs_q  = 2'b11;
   logic [1:0]  sck_q = 2'b00;

   // Reply bit the flash presents for SCK rise number j (bits 8..31 carry ID)
   function automatic logic flash_bit(input logic [23:0] resp, input int j);
      if (j >= 8 && j < 32) return resp[31 - j];
      return 1'($urandom);
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         cs_q[d]  <= w_cs[d];
         sck_q[d] <= w_sck[d];
         ids_q[d] <= w_ids[d];
         if (reset) begin
            k[d]      <= 0;
            hi_run[d] <= 0;
         end else begin
            if (w_busy[d]) busy_tot[d] <= busy_tot[d] + 1;
            if (w_done[d]) done_tot[d] <= done_tot[d] + 1;
            if (w_ids[d] !== ids_q[d] && !w_done[d]) glitch[d] <= glitch[d] + 1;
            if (w_cs[d]) begin
               hi_run[d] <= hi_run[d] + 1;
            end else begin
               hi_run[d] <= 0;
               cs_tot[d] <= cs_tot[d] + 1;
               if (w_sck[d]) hi_tot[d] <= hi_tot[d] + 1;
               if (cs_q[d]) begin
                  k[d]        <= 0;
                  op[d]       <= 8'd0;
                  resp_cur[d] <= resp_tab[d][txn[d] % 8];
                  txn[d]      <= txn[d] + 1;
                  gap_last[d] <= hi_run[d];
                  r_miso[d]   <= 1'($urandom);
               end else if (w_sck[d] && !sck_q[d]) begin
                  rises_tot[d] <= rises_tot[d] + 1;
                  if (k[d] < 8) op[d] <= {op[d][6:0], w_mosi[d]};
                  k[d]      <= k[d] + 1;
                  r_miso[d] <= flash_bit(resp_cur[d], k[d] + 1);
               end
            end
         end
      end
   end

   // ---------------- checking helpers ----------------
   int b_rise [2], b_cs [2], b_busy [2], b_hi [2], b_done [2], b_gl [2];

   function automatic int cd_of(input int d);
      return (d == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap(input int d);
      b_rise[d] = rises_tot[d];
      b_cs[d]   = cs_tot[d];
      b_busy[d] = busy_tot[d];
      b_hi[d]   = hi_tot[d];
      b_done[d] = done_tot[d];
      b_gl[d]   = glitch[d];
   endtask

   task automatic arm(input int d, input logic [23:0] r0, input logic [23:0] r1);
      resp_tab[d][txn[d] % 8]       = r0;
      resp_tab[d][(txn[d] + 1) % 8] = r1;
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) if4.start = v;
      else        if1.start = v;
   endtask

   task automatic pulse_start(input int d);
      @(negedge clk);
      set_start(d, 1'b1);
      @(negedge clk);
      set_start(d, 1'b0);
   endtask

   task automatic wait_idle(input int d, input int budget);
      int n = 0;
      while (w_busy[d] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle_timeout%0d", d), 32'(w_busy[d]), 32'd0);
   endtask

   task automatic wait_done(input int d, input int budget);
      int n = 0;
      while (!w_done[d] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("done_timeout%0d", d), 32'(w_done[d]), 32'd1);
   endtask

   task automatic verify(input int d, input logic [23:0] resp, input int ntx, input string tag);
      int cd = cd_of(d);
      chk($sformatf("%s.sck_rises", tag), rises_tot[d] - b_rise[d], 32 * ntx);
      chk($sformatf("%s.opcode", tag),    op[d], 8'h9F);
      chk($sformatf("%s.cs_low", tag),    cs_tot[d] - b_cs[d], 66 * cd * ntx);
      chk($sformatf("%s.busy", tag),      busy_tot[d] - b_busy[d], 67 * cd * ntx);
      chk($sformatf("%s.sck_high", tag),  hi_tot[d] - b_hi[d], 32 * cd * ntx);
      chk($sformatf("%s.done", tag),      done_tot[d] - b_done[d], ntx);
      chk($sformatf("%s.id_glitch", tag), glitch[d] - b_gl[d], 0);
      chk($sformatf("%s.manufacture_id", tag),  w_ids[d][23:16], resp[23:16]);
      chk($sformatf("%s.memory_type", tag),     w_ids[d][15:8],  resp[15:8]);
      chk($sformatf("%s.memory_capacity", tag), w_ids[d][7:0],   resp[7:0]);
      chk($sformatf("%s.valid", tag),     w_valid[d], 1'b1);
   endtask

   task automatic run_tx(input int d, input logic [23:0] resp, input string tag);
      arm(d, resp, resp);
      snap(d);
      pulse_start(d);
      wait_idle(d, 80 * cd_of(d) + 40);
      verify(d, resp, 1, tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [23:0] r;

      if4.start = 1'b0;
      if1.start = 1'b0;

      // reset state, with start pulsed while reset is held
      repeat (2) @(negedge clk);
      set_start(0, 1'b1);
      set_start(1, 1'b1);
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d.cs", d),    w_cs[d],    1'b1);
         chk($sformatf("rst%0d.sck", d),   w_sck[d],   1'b0);
         chk($sformatf("rst%0d.mosi", d),  w_mosi[d],  1'b0);
         chk($sformatf("rst%0d.busy", d),  w_busy[d],  1'b0);
         chk($sformatf("rst%0d.done", d),  w_done[d],  1'b0);
         chk($sformatf("rst%0d.valid", d), w_valid[d], 1'b0);
         chk($sformatf("rst%0d.ids", d),   w_ids[d],   24'h000000);
      end
      set_start(0, 1'b0);
      set_start(1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("post_rst%0d.busy", d), w_busy[d], 1'b0);
         chk($sformatf("post_rst%0d.cs", d),   w_cs[d],   1'b1);
      end

      // basic read
      run_tx(0, 24'h202015, "basic");

      // randomized reads
      for (int i = 0; i < 2; i++) begin
         r = 24'($urandom);
         run_tx(0, r, $sformatf("rand%0d", i));
      end

      // start while busy is ignored
      r = 24'($urandom);
      arm(0, r, r);
      snap(0);
      pulse_start(0);
      repeat (98) @(negedge clk);
      pulse_start(0);
      wait_idle(0, 400);
      verify(0, r, 1, "start_busy");

      // reset mid-transfer (during bit 12)
      r = 24'($urandom);
      arm(0, r, r);
      pulse_start(0);
      repeat (101) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("midrst.cs",    w_cs[0],    1'b1);
      chk("midrst.sck",   w_sck[0],   1'b0);
      chk("midrst.mosi",  w_mosi[0],  1'b0);
      chk("midrst.busy",  w_busy[0],  1'b0);
      chk("midrst.valid", w_valid[0], 1'b0);
      chk("midrst.ids",   w_ids[0],   24'h000000);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_tx(0, 24'h202015, "after_rst");

      // back-to-back with start held high
      arm(0, 24'h202015, 24'hEF4018);
      snap(0);
      @(negedge clk);
      set_start(0, 1'b1);
      wait_done(0, 400);
      chk("b2b.first_ids", w_ids[0], 24'h202015);
      @(negedge clk);
      wait_done(0, 400);
      set_start(0, 1'b0);
      chk("b2b.second_ids", w_ids[0], 24'hEF4018);
      wait_idle(0, 100);
      chk("b2b.cs_gap_ge4", 32'(gap_last[0] >= 4), 32'd1);
      verify(0, 24'hEF4018, 2, "b2b");

      // fastest divider
      run_tx(1, 24'h202015, "fast0");
      for (int i = 1; i < 3; i++) begin
         r = 24'($urandom);
         run_tx(1, r, $sformatf("fast%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/rdid_controller.md
# rdid_controller

Sequences the SPI flash Read-Identification (RDID, opcode 0x9F) transaction and captures the three identification bytes for display. On a `start` pulse it drives chip select, clocks out the opcode and reads 24 bits back in SPI mode 0. It then presents `manufacture_id`, `memory_type` and `memory_capacity` as stable registered bytes to the LED selection mux. It sits between the board SPI flash pins and the LED mux, and is the only master on the flash bus.

## Interface

- `CLK_DIV`, default 4: SCK half-period in `clk` cycles. Legal range is ≥1; SCK frequency = f_clk / (2·CLK_DIV).

Ports:

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse when the ID registers update.
- `valid`  out  1  high once at least one transaction has completed since reset.
- `manufacture_id`  out  8  first byte read.
- `memory_type`  out  8  second byte read.
- `memory_capacity`  out  8  third byte read.
- `CS`  out  1  flash chip select, active-low.
- `SCK`  out  1  SPI clock; idles low.
- `MOSI`  out  1  serial data to the flash.
- `MISO`  in  1  serial data from the flash.

## Operation

- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP.
- **IDLE:** `CS`=1, `SCK`=0, `MOSI`=0, `busy`=0. If `start`=1 at a clock edge, go to CS_SETUP.
- **CS_SETUP:** lasts CLK_DIV cycles. `CS`=0, `SCK`=0, `MOSI`=bit 7 of 0x9F. Then go to SHIFT with bit counter = 0.
- **SHIFT:** 32 bits, each 2·CLK_DIV cycles.
  - First CLK_DIV cycles: `SCK`=0.
  - Last CLK_DIV cycles: `SCK`=1.
  - `MISO` is sampled into a 24-bit shift register (MSB first) on the edge where `SCK` rises, for bits 8–31 only.
  - `MOSI` changes only on the edge where `SCK` falls. For bits 0–7 it carries opcode 0x9F MSB first; for bits 8–31 it is 0.
  - After bit 31's high phase, `SCK` returns to 0 and the state goes to CS_HOLD.
- **CS_HOLD:** lasts CLK_DIV cycles. `CS`=0, `SCK`=0, `MOSI`=0. On exit:
  - `CS`=1.
  - Shift register [23:16] → `manufacture_id`, [15:8] → `memory_type`, [7:0] → `memory_capacity`.
  - `valid`=1, `done`=1 for exactly one cycle.
  - Go to GAP.
- **GAP:** lasts CLK_DIV cycles with `CS`=1 and `busy`=1 (guarantees minimum CS-deselect time). Then go to IDLE.
- ID registers change only at `done`. Between transactions they hold their last values.
- `start` outside IDLE is ignored and is not queued.
- If `start` is held high continuously, back-to-back transactions run, with GAP between them.
- No data checking: an absent flash (MISO stuck high) yields 0xFF bytes with `valid`=1.
- Counters: the bit counter is 5 bits (0–31). The phase counter counts 0..CLK_DIV−1 and wraps.
- **Reset (asynchronous, any state including mid-SHIFT):**
  - State IDLE.
  - `CS`=1, `SCK`=0, `MOSI`=0, `busy`=0, `done`=0, `valid`=0.
  - All three ID bytes = 0x00; shift register and counters cleared.
  - Outputs change without waiting for a `clk` edge.

## Timing

- Edge 0 is the edge where `start` is accepted. `CS` falls after edge 0.
- `CS` low duration: exactly 66·CLK_DIV cycles (CS_SETUP + 64·CLK_DIV + CS_HOLD).
- `done` and ID update occur on edge 66·CLK_DIV. `done` is high for the following cycle.
- `busy` high duration: 67·CLK_DIV cycles. With CLK_DIV=4, `busy` is high for 268 cycles.
- First SCK rising edge occurs on edge 2·CLK_DIV.
- Each `MISO` sample uses the value present at the clock edge where `SCK` goes 0→1.
- Every output is registered; no combinational path from `MISO` or `start` to any output.

## Test plan

- **Reset:** hold `reset`=1 → `CS`=1, `SCK`=0, `MOSI`=0, `busy`=`done`=`valid`=0, all IDs 0x00. Also check that `start` pulses during reset are ignored.
- **Basic read:** CLK_DIV=4, flash model returns 0x20, 0x20, 0x15; pulse `start` →
  - exactly 32 SCK rising edges;
  - `MOSI` at the first 8 rising edges = 1,0,0,1,1,1,1,1;
  - `CS` low for exactly 264 cycles;
  - single `done` pulse;
  - `manufacture_id`=0x20, `memory_type`=0x20, `memory_capacity`=0x15, `valid`=1.
- **Start while busy:** pulse `start` again 100 cycles into a transaction → only 32 SCK edges total, one `done`, `busy` for 268 cycles.
- **Reset mid-transfer:** assert `reset` during bit 12 → `CS`=1 and `SCK`=0 before the next `clk` edge, IDs 0x00, `valid`=0. A subsequent `start` completes a normal read with 0x20/0x20/0x15.
- **Back-to-back:** hold `start` high; model returns 0x20/0x20/0x15 then 0xEF/0x40/0x18 →
  - `CS` high for ≥4 cycles between transactions;
  - IDs are 0x20/0x20/0x15 until the second `done`, then 0xEF/0x40/0x18.
- **Fastest divider:** CLK_DIV=1 → `SCK` toggles every cycle in SHIFT, `CS` low for 66 cycles, correct bytes captured.
